// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counting timer with prescaler, pause/resume and auto-reload
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          asynchronous active-low reset
//   load         capture load_val into count and the reload register, go IDLE
//   load_val     value captured on load
//   start        start from IDLE, resume from PAUSE, restart from DONE
//   pause        freeze countdown while in RUN
//   clear        synchronous abort to IDLE with count=0 (reload kept)
//   auto_reload  sampled at expiry: 1 = reload and keep running
//   count        current remaining count
//   busy         high in RUN or PAUSE
//   done         registered one-cycle pulse at each expiry
//   expired      level, high in DONE until load/clear/start
//
// PRESCALE is the number of clk cycles per decrement and must be >= 1.

module countdown_timer #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic [PW-1:0]    pre_cnt;

    logic tick;
    logic expire;

    // With PRESCALE=1 pre_cnt is stuck at 0 and every RUN cycle is a tick.
    assign tick   = (pre_cnt == PRE_MAX);
    // The expiring tick takes precedence over a same-cycle pause.
    assign expire = (state == S_RUN) && tick && (count == WIDTH'(1));

    assign busy = (state == S_RUN) || (state == S_PAUSE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            count   <= '0;
            reload  <= '0;
            pre_cnt <= '0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state   <= S_IDLE;
                count   <= '0;
                pre_cnt <= '0;
                expired <= 1'b0;
            end else if (load) begin
                state   <= S_IDLE;
                count   <= load_val;
                reload  <= load_val;
                pre_cnt <= '0;
                expired <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && (count != '0)) begin
                            state   <= S_RUN;
                            pre_cnt <= '0;
                        end
                    end
                    S_PAUSE: begin
                        // pre_cnt is retained so the partial prescale period resumes.
                        if (start) begin
                            state <= S_RUN;
                        end
                    end
                    S_DONE: begin
                        if (start && (reload != '0)) begin
                            state   <= S_RUN;
                            count   <= reload;
                            pre_cnt <= '0;
                            expired <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
                        if (expire) begin
                            done <= 1'b1;
                            if (auto_reload) begin
                                count <= reload;
                            end else begin
                                count   <= '0;
                                expired <= 1'b1;
                                state   <= S_DONE;
                            end
                        end else begin
                            // count never wraps below zero.
                            if (tick && (count > WIDTH'(1))) begin
                                count <= count - WIDTH'(1);
                            end
                            if (pause) begin
                                state <= S_PAUSE;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer at PRESCALE=1 and PRESCALE=4
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         clear = 1'b0;
    logic         auto_reload = 1'b0;

    logic [W-1:0] count1, count2;
    logic         busy1, busy2, done1, done2, exp1, exp2;

    countdown_timer #(.WIDTH(W), .PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .clear(clear), .auto_reload(auto_reload),
        .count(count1), .busy(busy1), .done(done1), .expired(exp1)
    );

    countdown_timer #(.WIDTH(W), .PRESCALE(4)) u_p4 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .clear(clear), .auto_reload(auto_reload),
        .count(count2), .busy(busy2), .done(done2), .expired(exp2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: one entry per DUT (index 0: PRESCALE=1, index 1: PRESCALE=4).
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;
    int m_mode[2];
    int m_cnt[2];
    int m_rl[2];
    int m_phase[2];
    int m_done[2];
    int m_exp[2];
    int m_p[2] = '{1, 4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = M_IDLE; m_cnt[d] = 0; m_rl[d] = 0;
            m_phase[d] = 0; m_done[d] = 0; m_exp[d] = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            m_done[d] = 0;
            if (clear) begin
                m_mode[d] = M_IDLE; m_cnt[d] = 0; m_phase[d] = 0; m_exp[d] = 0;
            end else if (load) begin
                m_mode[d] = M_IDLE; m_cnt[d] = int'(load_val); m_rl[d] = int'(load_val);
                m_phase[d] = 0; m_exp[d] = 0;
            end else if (m_mode[d] == M_IDLE) begin
                if (start && m_cnt[d] != 0) begin m_mode[d] = M_RUN; m_phase[d] = 0; end
            end else if (m_mode[d] == M_PAUSE) begin
                if (start) m_mode[d] = M_RUN;
            end else if (m_mode[d] == M_DONE) begin
                if (start && m_rl[d] != 0) begin
                    m_mode[d] = M_RUN; m_cnt[d] = m_rl[d]; m_phase[d] = 0; m_exp[d] = 0;
                end
            end else begin
                // One decrement every m_p cycles of RUN; phase counts cycles within the period.
                bit fired;
                bit expiry;
                m_phase[d] = (m_phase[d] + 1) % m_p[d];
                fired = (m_phase[d] == 0);
                expiry = fired && (m_cnt[d] == 1);
                if (expiry) begin
                    m_done[d] = 1;
                    if (auto_reload) m_cnt[d] = m_rl[d];
                    else begin m_cnt[d] = 0; m_exp[d] = 1; m_mode[d] = M_DONE; end
                end else begin
                    if (fired && m_cnt[d] > 1) m_cnt[d] = m_cnt[d] - 1;
                    if (pause) m_mode[d] = M_PAUSE;
                end
            end
        end
    endtask

    task automatic compare();
        check("p1_count",   32'(count1), 32'(m_cnt[0]));
        check("p1_busy",    32'(busy1),  32'(m_mode[0] == M_RUN || m_mode[0] == M_PAUSE));
        check("p1_done",    32'(done1),  32'(m_done[0]));
        check("p1_expired", 32'(exp1),   32'(m_exp[0]));
        check("p4_count",   32'(count2), 32'(m_cnt[1]));
        check("p4_busy",    32'(busy2),  32'(m_mode[1] == M_RUN || m_mode[1] == M_PAUSE));
        check("p4_done",    32'(done2),  32'(m_done[1]));
        check("p4_expired", 32'(exp2),   32'(m_exp[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load_val = v; load = 1'b1; cyc(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    // Cycles after the start edge until done is seen on the chosen DUT, or -1 on timeout.
    task automatic wait_done(input int d, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            cyc();
            if ((d == 0 && done1) || (d == 1 && done2)) begin
                lat = i;
                break;
            end
        end
    endtask

    // Asynchronous reset pulse placed between clock edges; checked before any edge arrives.
    task automatic async_reset_pulse();
        #2 rst = 1'b0;
        #1 model_reset();
        compare();
        #1 rst = 1'b1;
    endtask

    int lat;
    int ndone;

    initial begin
        #1 model_reset();
        compare();
        #3 rst = 1'b1;

        // Basic countdown from 5.
        do_load(8'd5);
        do_start();
        wait_done(0, 20, lat);
        check("basic_latency", 32'(lat), 32'd5);
        check("basic_expired", 32'(exp1), 32'd1);
        check("basic_busy", 32'(busy1), 32'd0);

        // Prescaled countdown from 3, then restart from DONE.
        do_load(8'd3);
        do_start();
        wait_done(1, 40, lat);
        check("prescale_latency", 32'(lat), 32'd12);
        do_start();
        wait_done(1, 40, lat);
        check("prescale_restart_latency", 32'(lat), 32'd12);

        // Auto-reload from 2 for 10 cycles.
        auto_reload = 1'b1;
        do_load(8'd2);
        do_start();
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (done1) ndone++;
        end
        check("autoreload_pulses", 32'(ndone), 32'd5);
        auto_reload = 1'b0;

        // Pause at count 3 for 7 cycles, then resume.
        do_load(8'd6);
        do_start();
        cyc(); cyc();
        pause = 1'b1; cyc(); pause = 1'b0;
        check("pause_held", 32'(count1), 32'd3);
        for (int i = 0; i < 7; i++) cyc();
        check("pause_busy", 32'(busy1), 32'd1);
        do_start();
        wait_done(0, 20, lat);
        check("pause_total_latency", 32'(11 + lat), 32'd14);

        // load and start together: load wins.
        load_val = 8'd9; load = 1'b1; start = 1'b1; cyc(); idle_inputs();
        check("load_start_busy", 32'(busy1), 32'd0);

        // clear on the expiry cycle of the PRESCALE=1 timer.
        do_load(8'd2);
        do_start();
        cyc();
        clear = 1'b1; cyc(); clear = 1'b0;
        check("clear_expiry_done", 32'(done1), 32'd0);

        // start with count 0 in IDLE.
        do_start();
        check("start_zero_busy", 32'(busy1), 32'd0);

        // Maximum load value.
        do_load(8'hFF);
        do_start();
        cyc();
        check("maxval_first_dec", 32'(count1), 32'd254);

        // Asynchronous reset mid-run at count 4, then no done afterwards.
        do_load(8'd6);
        do_start();
        cyc(); cyc();
        async_reset_pulse();
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (done1 || done2) ndone++;
        end
        check("reset_no_done", 32'(ndone), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            load        = ($urandom_range(0, 99) < 5);
            load_val    = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 7));
            clear       = ($urandom_range(0, 99) < 3);
            start       = ($urandom_range(0, 99) < 25);
            pause       = ($urandom_range(0, 99) < 12);
            auto_reload = ($urandom_range(0, 99) < 35);
            cyc();
            if ($urandom_range(0, 199) == 0) async_reset_pulse();
        end
        idle_inputs();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counting timer for the soda machine controller, e.g. dispense valve on-time and coin-return timeout. Software or the FSM loads a count, starts it, and receives a one-cycle done pulse when it reaches zero. It complements the free-running up counter: counts down from a programmed value instead of up from zero, with an optional clock prescaler, pause/resume and auto-reload.

Parameters:
WIDTH, 32, width of count, load_val and the reload register
PRESCALE, 1, clk cycles per count decrement; must be >= 1; prescale counter width is max(1, $clog2(PRESCALE))

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (rst==0 resets)
load  input  1  load load_val into count and the reload register
load_val  input  WIDTH  value captured on load
start  input  1  start from IDLE, resume from PAUSE, restart from DONE
pause  input  1  freeze countdown while in RUN
clear  input  1  synchronous abort to IDLE with count=0
auto_reload  input  1  sampled at expiry; 1 = reload and keep running
count  output  WIDTH  current remaining count
busy  output  1  high in RUN or PAUSE (decoded from state register)
done  output  1  registered one-cycle pulse at each expiry
expired  output  1  level, high in DONE until load/clear/start

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE, count=0, reload=0, pre_cnt=0, done=0, expired=0, busy=0.
- States: IDLE, RUN, PAUSE, DONE. done defaults to 0 every cycle unless set below.
- Per-cycle priority: clear > load > start > pause. Lower-priority requests in the same cycle are ignored.
- clear (any state): state=IDLE, count=0, pre_cnt=0, expired=0. The reload register is kept. No done pulse, even if expiry coincides.
- load (any state): count=load_val, reload=load_val, pre_cnt=0, expired=0, state=IDLE. Loading during RUN aborts the run.
- start:
  - In IDLE with count!=0: enter RUN, pre_cnt=0.
  - In IDLE with count==0: ignored.
  - In PAUSE: back to RUN, pre_cnt retained.
  - In DONE with reload!=0: count=reload, pre_cnt=0, expired=0, enter RUN.
  - In DONE with reload==0: ignored.
  - In RUN: ignored.
- RUN:
  - tick = (pre_cnt==PRESCALE-1). pre_cnt increments each cycle and wraps to 0 on tick.
  - On tick with count>1: count=count-1.
  - On tick with count==1 (expiry): done=1 for one cycle.
    - auto_reload==1: count=reload, stay RUN, expired stays 0.
    - auto_reload==0: count=0, expired=1, state=DONE.
- pause in RUN: state=PAUSE, count and pre_cnt frozen. A tick in the same cycle is still applied first; if that tick is the expiry, expiry wins (DONE, or RUN on auto-reload) and pause is dropped. pause in IDLE, PAUSE or DONE: ignored.
- Latency, PRESCALE=P, load value N:
  - start sampled at edge 0 → RUN.
  - Decrements at edges P, 2P, … NP.
  - done high in the cycle after edge NP, i.e. N*P cycles after the start edge.
- No wrap below zero: count never decrements from 0. count is only reloaded from reload, never from load_val directly outside a load.
- Arithmetic is unsigned WIDTH-bit. load_val = 2^WIDTH-1 is legal.
- Reset mid-run: immediate return to reset values. No done pulse.

Test Plan:
- Reset/basic, PRESCALE=1: rst=0 → all outputs 0. Release, load 5, start. Required: count 5,4,3,2,1,0 on successive cycles; done high exactly once, 5 cycles after the start edge; expired=1; busy=0 afterwards.
- Prescale, PRESCALE=4: load 3, start. Required: count decrements every 4 cycles; done 12 cycles after start; start again in DONE → reload 3 and repeat identically.
- Auto-reload, auto_reload=1: load 2, start, run 10 cycles. Required: done pulses every 2 cycles; count sequence 2,1,2,1…; expired stays 0; busy stays 1.
- Pause/resume: load 6, start, pause at count=3 for 7 cycles, then start. Required: count held at 3 and busy=1 while paused; resumes 2,1,0; total start-to-done = 6 + 7 + 1 (resume cycle) = 14 cycles.
- Priority/corner cases:
  - load and start in the same cycle → IDLE with the new value.
  - clear on the expiry cycle → no done, count=0.
  - start with count=0 in IDLE → no change.
  - load 2^WIDTH-1 → first decrement gives 2^WIDTH-2.
- Async reset mid-run: assert rst between clock edges at count=4. Required: count=0 and busy=0 immediately, with no clock edge needed; no done pulse after release.
